keypad_matrix_emulator: RTL and testbench

- Behavioural responder for the 4x4 matrix keypad protocol. It sits on the far side of the row/col interface from the keypad scanner.
- The scanner drives rows; this block returns col levels for one simulated key. The key is pressed, held and released with contact bounce.
- Used in loopback/self-test builds and benches to exercise the scan, debounce and display path without a physical keypad.

---
 rtl/keypad_matrix_emulator.sv | 131 +++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_emulator.sv
// Emulated 4x4 keypad switch: one press/hold/release with LFSR-driven contact bounce,
// answering scanner row strobes on col one cycle later; press_req only taken in IDLE.
module keypad_matrix_emulator #(
  parameter int          BOUNCE_CYCLES = 50000,
  parameter int          HOLD_CYCLES   = 1000000,
  parameter int          BOUNCE_TOGGLE = 500,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       press_req,
  input  logic [3:0] press_key,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       busy,
  output logic       contact,
  output logic       done
);

  localparam int PHASE_MAX = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int PW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int TW        = (BOUNCE_TOGGLE > 1) ? $clog2(BOUNCE_TOGGLE) : 1;

  localparam logic [PW-1:0] BOUNCE_LAST = PW'(BOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] HOLD_LAST   = PW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TOGGLE_LAST = TW'(BOUNCE_TOGGLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_BOUNCE,
    S_HOLD,
    S_RELEASE_BOUNCE,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_phase;
  logic [TW-1:0] r_toggle;
  logic [15:0]   r_lfsr;
  logic [3:0]    r_key;
  logic [3:0]    r_col;
  logic          r_busy;
  logic          r_contact;
  logic          r_done;
  logic          w_fb;

  assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign col     = r_col;
  assign busy    = r_busy;
  assign contact = r_contact;
  assign done    = r_done;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_toggle  <= '0;
      r_lfsr    <= LFSR_SEED;
      r_key     <= 4'h0;
      r_busy    <= 1'b0;
      r_contact <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (r_state != S_IDLE) begin
        r_lfsr <= {r_lfsr[14:0], w_fb};
      end
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The done pulse is visible while already back in IDLE; a request
          // arriving alongside it belongs to the finished sequence and is dropped.
          if (press_req && !r_done) begin
            r_key    <= press_key;
            r_busy   <= 1'b1;
            r_phase  <= '0;
            r_toggle <= '0;
            r_state  <= S_PRESS_BOUNCE;
          end
        end
        S_PRESS_BOUNCE, S_RELEASE_BOUNCE: begin
          if (r_toggle == TOGGLE_LAST) begin
            r_contact <= r_lfsr[0];
            r_toggle  <= '0;
          end else begin
            r_toggle <= r_toggle + 1'b1;
          end
          if (r_phase == BOUNCE_LAST) begin
            r_phase <= '0;
            if (r_state == S_PRESS_BOUNCE) begin
              r_contact <= 1'b1;
              r_state   <= S_HOLD;
            end else begin
              r_contact <= 1'b0;
              r_state   <= S_DONE;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_HOLD: begin
          if (r_phase == HOLD_LAST) begin
            r_phase  <= '0;
            r_toggle <= '0;
            r_state  <= S_RELEASE_BOUNCE;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Only the selected row strobe matters; other rows may be low at the same time.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_col <= 4'hF;
    end else begin
      r_col <= 4'hF;
      if (r_contact && !row[r_key[3:2]]) begin
        r_col[r_key[1:0]] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator with short bounce/hold windows.
module tb_keypad_matrix_emulator;

  logic       clk = 1'b0;
  logic       RSTn = 1'b1;
  logic       press_req = 1'b0;
  logic [3:0] press_key = 4'h0;
  logic [3:0] row = 4'hF;
  logic [3:0] col;
  logic       busy;
  logic       contact;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [15:0] lf [0:80];
  logic [3:0]  walk [4];

  keypad_matrix_emulator #(
    .BOUNCE_CYCLES(16),
    .HOLD_CYCLES  (32),
    .BOUNCE_TOGGLE(2),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk      (clk),
    .RSTn     (RSTn),
    .press_req(press_req),
    .press_key(press_key),
    .row      (row),
    .col      (col),
    .busy     (busy),
    .contact  (contact),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request; n counts clock edges after the accept edge.
  task automatic run_seq(input logic [3:0] k, input logic [3:0] r, input logic [3:0] hold_col);
    press_key = k;
    row       = r;
    press_req = 1'b1;
    tick();
    press_req = 1'b0;
    for (int n = 0; n <= 68; n++) begin
      chk($sformatf("seq%0d_busy_n%0d", k, n), {15'd0, busy}, {15'd0, (n <= 64)});
      chk($sformatf("seq%0d_done_n%0d", k, n), {15'd0, done}, {15'd0, (n == 65)});
      if (n >= 17 && n <= 48) begin
        chk($sformatf("seq%0d_holdcol_n%0d", k, n), {12'd0, col}, {12'd0, hold_col});
      end else if (n == 0 || n >= 66) begin
        chk($sformatf("seq%0d_idlecol_n%0d", k, n), {12'd0, col}, 16'h000F);
      end
      if (n == 32) chk($sformatf("seq%0d_hold_contact", k), {15'd0, contact}, 16'd1);
      tick();
    end
  endtask

  initial begin
    logic       cexp;
    logic       pc;
    logic [3:0] prow;

    walk[0] = 4'hE; walk[1] = 4'hD; walk[2] = 4'hB; walk[3] = 4'h7;
    lf[0] = 16'hACE1;
    for (int i = 1; i <= 80; i++) begin
      lf[i] = {lf[i-1][14:0], lf[i-1][15] ^ lf[i-1][13] ^ lf[i-1][12] ^ lf[i-1][10]};
    end

    // Reset held with all rows low and a request pending.
    #2;
    RSTn      = 1'b0;
    row       = 4'h0;
    press_req = 1'b1;
    press_key = 4'h6;
    repeat (3) tick();
    chk("rst_col",     {12'd0, col},     16'h000F);
    chk("rst_busy",    {15'd0, busy},    16'd0);
    chk("rst_contact", {15'd0, contact}, 16'd0);
    chk("rst_done",    {15'd0, done},    16'd0);
    press_req = 1'b0;
    RSTn      = 1'b1;
    tick();
    chk("idle_busy", {15'd0, busy}, 16'd0);
    chk("idle_col",  {12'd0, col},  16'h000F);

    // Key 6 with walking row, checked every cycle against the LFSR model.
    row       = 4'hF;
    press_key = 4'h6;
    press_req = 1'b1;
    chk("pre_accept_busy", {15'd0, busy}, 16'd0);
    tick();
    press_req = 1'b0;
    cexp = 1'b0;
    pc   = 1'b0;
    prow = 4'hF;
    for (int n = 0; n <= 70; n++) begin
      if (((n >= 2 && n <= 14) || (n >= 50 && n <= 62)) && (n % 2 == 0)) cexp = lf[n-1][0];
      else if (n == 16) cexp = 1'b1;
      else if (n == 64) cexp = 1'b0;
      chk($sformatf("k6_contact_n%0d", n), {15'd0, contact}, {15'd0, cexp});
      chk($sformatf("k6_busy_n%0d", n),    {15'd0, busy},    {15'd0, (n <= 64)});
      chk($sformatf("k6_done_n%0d", n),    {15'd0, done},    {15'd0, (n == 65)});
      chk($sformatf("k6_col_n%0d", n),     {12'd0, col},
          (pc && !prow[1]) ? 16'h000B : 16'h000F);
      row       = walk[n % 4];
      press_req = (n == 30 || n == 64 || n == 65);
      press_key = (n == 30) ? 4'h0 : 4'h3;
      pc   = cexp;
      prow = row;
      tick();
    end
    press_req = 1'b0;

    // Asynchronous reset in the middle of HOLD.
    row       = 4'hD;
    press_key = 4'h6;
    press_req = 1'b1;
    tick();
    press_req = 1'b0;
    repeat (25) tick();
    chk("midhold_col_before", {12'd0, col},     16'h000B);
    chk("midhold_contact",    {15'd0, contact}, 16'd1);
    RSTn = 1'b0;
    #1;
    chk("async_rst_col",     {12'd0, col},     16'h000F);
    chk("async_rst_busy",    {15'd0, busy},    16'd0);
    chk("async_rst_contact", {15'd0, contact}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_nodone_%0d", i), {15'd0, done}, 16'd0);
    end
    RSTn = 1'b1;
    tick();
    chk("post_rst_busy", {15'd0, busy}, 16'd0);

    run_seq(4'hF, 4'h0, 4'h7);
    run_seq(4'h0, 4'hF, 4'hF);
    run_seq(4'h6, 4'hD, 4'hB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
